// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and encodings for the retire-trace checker
package trace_pkg;

    localparam int GOLD_W    = 102;
    localparam int PC_LSB    = 70;
    localparam int INST_LSB  = 38;
    localparam int WE_BIT    = 37;
    localparam int WADDR_LSB = 32;
    localparam int WDATA_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam int ERR_PC   = 0;
    localparam int ERR_INST = 1;
    localparam int ERR_RF   = 2;

    // Field order matches the golden ROM packing, so a raw entry casts directly.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

endpackage

// File: rtl/trace_cmp.sv
// rtl/trace_cmp.sv - combinational per-field compare of one retirement against its golden entry
module trace_cmp
    import trace_pkg::*;
#(
    parameter bit CHECK_RF = 1'b1
) (
    input  entry_t     sample,
    input  entry_t     gold,
    output logic [2:0] field_err
);

    logic rf_diff;

    always_comb begin
        field_err = '0;
        // With both write enables low the destination fields are don't-care.
        rf_diff   = (sample.we != gold.we) ||
                    (gold.we && ((sample.waddr != gold.waddr) || (sample.wdata != gold.wdata)));
        field_err[ERR_PC]   = sample.pc != gold.pc;
        field_err[ERR_INST] = sample.inst != gold.inst;
        field_err[ERR_RF]   = CHECK_RF && rf_diff;
    end

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - in-order retire trace check against an external golden ROM
module trace_checker
    import trace_pkg::*;
#(
    parameter int IDX_W     = 12,
    parameter int TRACE_LEN = 2500,
    parameter bit CHECK_RF  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [31:0]       rf_wdata,
    output logic [IDX_W-1:0]  gold_addr,
    input  logic [GOLD_W-1:0] gold_data,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [IDX_W-1:0]  err_index,
    output logic [2:0]        err_field,
    output logic [31:0]       err_pc,
    output logic [IDX_W:0]    checked_cnt
);

    localparam logic [IDX_W:0] LEN = (IDX_W+1)'(TRACE_LEN);

    logic [1:0]     state;
    logic [IDX_W:0] idx;
    entry_t         sample;
    entry_t         gold;
    logic           cmp_v;
    logic [2:0]     field_err;
    logic           fail_now;
    logic           accept;

    assign gold = gold_data;

    trace_cmp #(.CHECK_RF(CHECK_RF)) u_cmp (
        .sample    (sample),
        .gold      (gold),
        .field_err (field_err)
    );

    // A failing compare suppresses the concurrent accept so nothing follows the first divergence.
    assign fail_now = cmp_v && (|field_err);
    assign accept   = ((state == ST_IDLE) || (state == ST_RUN)) && en && (idx < LEN) && !fail_now;

    assign gold_addr = idx[IDX_W-1:0];
    assign done      = (state == ST_PASS) || (state == ST_FAIL);
    assign pass      = state == ST_PASS;
    assign mismatch  = state == ST_FAIL;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sample      <= '0;
            cmp_v       <= 1'b0;
            err_index   <= '0;
            err_field   <= '0;
            err_pc      <= '0;
            checked_cnt <= '0;
        end else begin
            cmp_v <= accept;
            if (accept) begin
                sample <= {pc, inst, rf_we, rf_waddr, rf_wdata};
                idx    <= idx + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (LEN == '0)
                        state <= ST_PASS;
                    else if (accept)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (cmp_v) begin
                        checked_cnt <= checked_cnt + 1'b1;
                        // idx already points one past the sample being compared.
                        if (|field_err) begin
                            err_index <= IDX_W'(idx - 1'b1);
                            err_field <= field_err;
                            err_pc    <= sample.pc;
                            state     <= ST_FAIL;
                        end else if (idx == LEN) begin
                            state <= ST_PASS;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed self-checking bench for trace_checker
module tb_trace_checker;
    import trace_pkg::*;

    localparam int IDX_W = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0, inst = '0, rf_wdata = '0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;

    logic [IDX_W-1:0]  gold_addr_a, gold_addr_b, err_index_a, err_index_b;
    logic [GOLD_W-1:0] gold_data_a, gold_data_b;
    logic              done_a, pass_a, mismatch_a, done_b, pass_b, mismatch_b;
    logic [2:0]        err_field_a, err_field_b;
    logic [31:0]       err_pc_a, err_pc_b;
    logic [IDX_W:0]    checked_cnt_a, checked_cnt_b;

    entry_t rom [0:4095];
    entry_t golden [0:3];
    entry_t stim [0:3];
    bit     pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        gold_data_a <= rom[gold_addr_a];
        gold_data_b <= rom[gold_addr_b];
    end

    trace_checker #(.IDX_W(IDX_W), .TRACE_LEN(4), .CHECK_RF(1'b1)) dut (
        .clock(clock), .reset(reset), .en(en), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .gold_addr(gold_addr_a), .gold_data(gold_data_a),
        .done(done_a), .pass(pass_a), .mismatch(mismatch_a),
        .err_index(err_index_a), .err_field(err_field_a), .err_pc(err_pc_a),
        .checked_cnt(checked_cnt_a)
    );

    trace_checker #(.IDX_W(IDX_W), .TRACE_LEN(4), .CHECK_RF(1'b0)) dut_norf (
        .clock(clock), .reset(reset), .en(en), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .gold_addr(gold_addr_b), .gold_data(gold_data_b),
        .done(done_b), .pass(pass_b), .mismatch(mismatch_b),
        .err_index(err_index_b), .err_field(err_field_b), .err_pc(err_pc_b),
        .checked_cnt(checked_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input entry_t e, input bit v);
        en = v;
        {pc, inst, rf_we, rf_waddr, rf_wdata} = e;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 4; i++) begin
            rom[i] = golden[i];
            stim[i] = golden[i];
        end
    endtask

    task automatic run_stim();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            apply(stim[i], 1'b1);
        end
        @(negedge clock);
        apply(stim[0], 1'b0);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_pass"}, 64'(pass_a), 64'd0);
        check({tag, "_mismatch"}, 64'(mismatch_a), 64'd0);
        check({tag, "_gold_addr"}, 64'(gold_addr_a), 64'd0);
        check({tag, "_checked_cnt"}, 64'(checked_cnt_a), 64'd0);
        check({tag, "_err_index"}, 64'(err_index_a), 64'd0);
        check({tag, "_err_field"}, 64'(err_field_a), 64'd0);
        check({tag, "_err_pc"}, 64'(err_pc_a), 64'd0);
    endtask

    initial begin
        int j;
        golden[0] = '{pc: 32'h00400000, inst: 32'h20080000, we: 1'b1, waddr: 5'd8, wdata: 32'h0};
        golden[1] = '{pc: 32'h00400004, inst: 32'h21080005, we: 1'b1, waddr: 5'd8, wdata: 32'h5};
        golden[2] = '{pc: 32'h00400008, inst: 32'h24080001, we: 1'b1, waddr: 5'd8, wdata: 32'h1};
        golden[3] = '{pc: 32'h0040000c, inst: 32'h25080002, we: 1'b1, waddr: 5'd8, wdata: 32'h3};
        for (int i = 0; i < 4096; i++) rom[i] = '0;

        // Matching trace, en every cycle, with one-cycle decision latency
        load_rom();
        do_reset();
        check_zero("reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            apply(stim[i], 1'b1);
        end
        @(negedge clock);
        check("t1_pass_not_yet", 64'(pass_a), 64'd0);
        apply(stim[0], 1'b0);
        @(negedge clock);
        check("t1_pass", 64'(pass_a), 64'd1);
        check("t1_done", 64'(done_a), 64'd1);
        check("t1_mismatch", 64'(mismatch_a), 64'd0);
        check("t1_cnt", 64'(checked_cnt_a), 64'd4);
        apply(stim[1], 1'b1);
        repeat (3) @(negedge clock);
        apply(stim[0], 1'b0);
        check("t1_gold_addr_held", 64'(gold_addr_a), 64'd4);
        check("t1_cnt_held", 64'(checked_cnt_a), 64'd4);
        check("t1_norf_pass", 64'(pass_b), 64'd1);

        // Instruction divergence at entry 2
        load_rom();
        stim[2].inst = 32'h24090001;
        do_reset();
        run_stim();
        check("t2_mismatch", 64'(mismatch_a), 64'd1);
        check("t2_done", 64'(done_a), 64'd1);
        check("t2_pass", 64'(pass_a), 64'd0);
        check("t2_err_index", 64'(err_index_a), 64'd2);
        check("t2_err_field", 64'(err_field_a), 64'd2);
        check("t2_err_pc", 64'(err_pc_a), 64'h00400008);
        check("t2_cnt", 64'(checked_cnt_a), 64'd3);
        apply(stim[3], 1'b1);
        repeat (3) @(negedge clock);
        apply(stim[0], 1'b0);
        check("t2_err_index_held", 64'(err_index_a), 64'd2);
        check("t2_cnt_held", 64'(checked_cnt_a), 64'd3);
        check("t2_norf_field", 64'(err_field_b), 64'd2);

        // Register write data divergence at entry 1
        load_rom();
        stim[1].wdata = 32'h6;
        do_reset();
        run_stim();
        check("t3_mismatch", 64'(mismatch_a), 64'd1);
        check("t3_err_field", 64'(err_field_a), 64'd4);
        check("t3_err_index", 64'(err_index_a), 64'd1);
        check("t3_err_pc", 64'(err_pc_a), 64'h00400004);
        check("t3_norf_pass", 64'(pass_b), 64'd1);
        check("t3_norf_mismatch", 64'(mismatch_b), 64'd0);

        // Both write enables low: wdata difference is ignored
        load_rom();
        rom[1].we = 1'b0;
        stim[1].we = 1'b0;
        stim[1].wdata = 32'h6;
        do_reset();
        run_stim();
        check("t3b_pass", 64'(pass_a), 64'd1);
        check("t3b_mismatch", 64'(mismatch_a), 64'd0);

        // Stalled retirements
        load_rom();
        do_reset();
        j = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            check($sformatf("t4_gold_addr_%0d", k), 64'(gold_addr_a), 64'(j));
            apply(stim[j % 4], pat[k]);
            if (pat[k]) j++;
        end
        @(negedge clock);
        apply(stim[0], 1'b0);
        check("t4_gold_addr_end", 64'(gold_addr_a), 64'd4);
        repeat (3) @(negedge clock);
        check("t4_pass", 64'(pass_a), 64'd1);
        check("t4_cnt", 64'(checked_cnt_a), 64'd4);

        // Reset in the middle of a run
        load_rom();
        do_reset();
        @(negedge clock);
        apply(stim[0], 1'b1);
        @(negedge clock);
        apply(stim[1], 1'b1);
        @(negedge clock);
        check("t5_idx_before", 64'(gold_addr_a), 64'd2);
        apply(stim[2], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_zero("t5_reset");
        reset = 1'b1;
        run_stim();
        check("t5_rerun_pass", 64'(pass_a), 64'd1);
        check("t5_rerun_cnt", 64'(checked_cnt_a), 64'd4);

        // Final entry wrong in pc and wdata
        load_rom();
        stim[3].pc = 32'h00400010;
        stim[3].wdata = 32'h7;
        do_reset();
        run_stim();
        check("t6_mismatch", 64'(mismatch_a), 64'd1);
        check("t6_pass", 64'(pass_a), 64'd0);
        check("t6_done", 64'(done_a), 64'd1);
        check("t6_err_field", 64'(err_field_a), 64'd5);
        check("t6_err_index", 64'(err_index_a), 64'd3);
        check("t6_err_pc", 64'(err_pc_a), 64'h00400010);
        check("t6_cnt", 64'(checked_cnt_a), 64'd4);
        check("t6_norf_field", 64'(err_field_b), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
